// File: rtl/shr_ctrl_pkg.sv
// Shared definitions for the shift-register pattern serializer.
//   shr_state_e : serializer FSM states
//   SHR_WIDTH   : pattern length of the DE0 shift-register chain
//   SHR_CLKDIV  : default clk cycles per shr_clk half-period
//   div_bits()  : width of the half-period divider counter
package shr_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LO,
        HI,
        LATCH
    } shr_state_e;

    localparam int unsigned SHR_WIDTH  = 620;
    localparam int unsigned SHR_CLKDIV = 4;

    // A divide-by-one still needs a one-bit counter to exist.
    function automatic int unsigned div_bits(input int unsigned clkdiv);
        return (clkdiv > 1) ? $clog2(clkdiv) : 1;
    endfunction

endpackage

// File: rtl/shr_pattern_serializer_if.sv
// Bus between the JTAG buffer stage and the serializer, plus the serial
// chain outputs and status.
//   pattern   : control word (stable while udr is low)
//   udr       : update strobe, tck domain
//   start     : synchronous one-cycle resend request
//   shr_clk   : serial clock to the chain
//   shr_data  : serial data
//   shr_latch : parallel-load strobe
//   busy      : transfer in progress
//   done      : one-cycle completion pulse
//   frame_cnt : completed transfers, modulo 256
// master drives pattern/udr/start; slave is the serializer.
interface shr_pattern_serializer_if #(
    parameter int unsigned WIDTH = shr_ctrl_pkg::SHR_WIDTH
);
    logic [WIDTH-1:0] pattern;
    logic             udr;
    logic             start;
    logic             shr_clk;
    logic             shr_data;
    logic             shr_latch;
    logic             busy;
    logic             done;
    logic [7:0]       frame_cnt;

    modport master (
        output pattern, udr, start,
        input  shr_clk, shr_data, shr_latch, busy, done, frame_cnt
    );

    modport slave (
        input  pattern, udr, start,
        output shr_clk, shr_data, shr_latch, busy, done, frame_cnt
    );
endinterface

// File: rtl/shr_pattern_serializer_sync_rise_det.sv
// Two-flop synchronizer followed by a registered rising-edge detector.
// Reusable for any slow strobe crossing from tck into clk.
//   clk    : destination clock
//   aclr   : asynchronous active-high reset
//   strobe : asynchronous level input
//   rise   : one-cycle pulse; strobe high at edge k gives rise high in
//            the cycle after edge k+2
module sync_rise_det (
    input  logic clk,
    input  logic aclr,
    input  logic strobe,
    output logic rise
);
    // [0],[1] form the synchronizer, [2] holds the previous synced level
    logic [2:0] sync_q;

    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            sync_q <= '0;
            rise   <= 1'b0;
        end else begin
            sync_q <= {sync_q[1:0], strobe};
            rise   <= sync_q[1] & ~sync_q[2];
        end
    end
endmodule

// File: rtl/shr_pattern_serializer.sv
// Takes the JTAG control-pattern word on udr (or a local start request)
// and shifts it out to the external shift-register chain as an SPI-like
// stream, finishing each frame with a latch strobe.
//   clk  : 50 MHz system clock
//   aclr : asynchronous active-high reset; aborts any transfer
//   bus  : slave side of shr_pattern_serializer_if (see that file)
// Each bit is CLKDIV cycles low then CLKDIV cycles high on shr_clk; data
// changes only on entry to the low phase. Triggers arriving while busy
// collapse into a single follow-up transfer.
module shr_pattern_serializer
    import shr_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH     = SHR_WIDTH,
    parameter int unsigned CLKDIV    = SHR_CLKDIV,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic                     clk,
    input  logic                     aclr,
    shr_pattern_serializer_if.slave  bus
);
    localparam int unsigned BIT_W = $clog2(WIDTH);
    localparam int unsigned DIV_W = div_bits(CLKDIV);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKDIV - 1);

    shr_state_e       state_q, state_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             pending_q, pending_d;
    logic [7:0]       frame_cnt_q, frame_cnt_d;
    logic             shr_clk_q, shr_clk_d;
    logic             shr_data_q, shr_data_d;
    logic             shr_latch_q, shr_latch_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             udr_rise;
    logic             trig;
    logic             div_end;
    logic             last_bit;

    sync_rise_det u_udr_sync (
        .clk    (clk),
        .aclr   (aclr),
        .strobe (bus.udr),
        .rise   (udr_rise)
    );

    assign trig     = udr_rise | bus.start;
    assign div_end  = (div_q == DIV_LAST);
    assign last_bit = (bit_cnt_q == BIT_LAST);

    always_comb begin
        state_d     = state_q;
        shadow_d    = shadow_q;
        bit_cnt_d   = bit_cnt_q;
        pending_d   = pending_q;
        frame_cnt_d = frame_cnt_q;
        done_d      = 1'b0;
        div_d       = '0;

        unique case (state_q)
            IDLE: begin
                // A trigger on the done cycle lands here too, so it behaves
                // exactly like a pending request.
                if (trig || pending_q) begin
                    state_d   = LO;
                    shadow_d  = bus.pattern;
                    bit_cnt_d = '0;
                    pending_d = 1'b0;
                end
            end
            LO: begin
                if (div_end) begin
                    state_d = HI;
                end
            end
            HI: begin
                if (div_end) begin
                    if (last_bit) begin
                        state_d = LATCH;
                    end else begin
                        state_d   = LO;
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        shadow_d  = MSB_FIRST ? {shadow_q[WIDTH-2:0], 1'b0}
                                              : {1'b0, shadow_q[WIDTH-1:1]};
                    end
                end
            end
            LATCH: begin
                if (div_end) begin
                    state_d     = IDLE;
                    done_d      = 1'b1;
                    frame_cnt_d = frame_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_q != IDLE && trig) begin
            pending_d = 1'b1;
        end

        // Divider restarts on every state change and is held at zero in IDLE.
        if (state_q != IDLE && state_d == state_q) begin
            div_d = div_q + 1'b1;
        end

        // Outputs are decoded from the next state so they register in step
        // with it and reach the pins glitch-free.
        shr_clk_d   = (state_d == HI);
        shr_latch_d = (state_d == LATCH);
        busy_d      = (state_d != IDLE);
        if (state_d == LO || state_d == HI) begin
            shr_data_d = MSB_FIRST ? shadow_d[WIDTH-1] : shadow_d[0];
        end else begin
            shr_data_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            state_q     <= IDLE;
            shadow_q    <= '0;
            bit_cnt_q   <= '0;
            div_q       <= '0;
            pending_q   <= 1'b0;
            frame_cnt_q <= '0;
            shr_clk_q   <= 1'b0;
            shr_data_q  <= 1'b0;
            shr_latch_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            shadow_q    <= shadow_d;
            bit_cnt_q   <= bit_cnt_d;
            div_q       <= div_d;
            pending_q   <= pending_d;
            frame_cnt_q <= frame_cnt_d;
            shr_clk_q   <= shr_clk_d;
            shr_data_q  <= shr_data_d;
            shr_latch_q <= shr_latch_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus.shr_clk   = shr_clk_q;
    assign bus.shr_data  = shr_data_q;
    assign bus.shr_latch = shr_latch_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.frame_cnt = frame_cnt_q;
endmodule

// File: tb/tb_shr_pattern_serializer.sv
// Self-checking bench for shr_pattern_serializer.
// Three instances: A (WIDTH 8, CLKDIV 2, MSB first), B (same, LSB first,
// driven identically to A) and C (WIDTH 620, CLKDIV 1).
module tb_shr_pattern_serializer;

    localparam int MW = 620;

    logic clk  = 1'b0;
    logic aclr = 1'b1;
    always #10 clk = ~clk;

    shr_pattern_serializer_if #(.WIDTH(8))   bus_a ();
    shr_pattern_serializer_if #(.WIDTH(8))   bus_b ();
    shr_pattern_serializer_if #(.WIDTH(620)) bus_c ();

    shr_pattern_serializer #(.WIDTH(8), .CLKDIV(2), .MSB_FIRST(1'b1)) dut_a (
        .clk(clk), .aclr(aclr), .bus(bus_a));
    shr_pattern_serializer #(.WIDTH(8), .CLKDIV(2), .MSB_FIRST(1'b0)) dut_b (
        .clk(clk), .aclr(aclr), .bus(bus_b));
    shr_pattern_serializer #(.WIDTH(620), .CLKDIV(1), .MSB_FIRST(1'b1)) dut_c (
        .clk(clk), .aclr(aclr), .bus(bus_c));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [MW-1:0] got, input logic [MW-1:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // ---------------- reference model / monitor ----------------
    int            wid [3] = '{8, 8, 620};
    int            dv  [3] = '{2, 2, 1};
    bit            msb [3] = '{1'b1, 1'b0, 1'b1};
    logic [MW-1:0] cap [3];
    logic [MW-1:0] expf [3][8];
    int            ewr [3], erd [3];
    int            ncap [3], lat_len [3], busy_len [3], mcnt [3];
    logic          p_clk [3], p_lat [3], p_busy [3], p_done [3];

    task automatic push_exp(input int id, input logic [MW-1:0] p);
        expf[id][ewr[id] % 8] = p;
        ewr[id]++;
    endtask

    task automatic mon_reset();
        for (int id = 0; id < 3; id++) begin
            erd[id] = ewr[id];
            ncap[id] = 0; lat_len[id] = 0; busy_len[id] = 0; mcnt[id] = 0;
            p_clk[id] = 1'b0; p_lat[id] = 1'b0; p_busy[id] = 1'b0; p_done[id] = 1'b0;
        end
    endtask

    task automatic mon(input int id, input logic sc, input logic sd, input logic sl,
                       input logic bs, input logic dn, input logic [7:0] fc);
        logic [MW-1:0] got, want, e;
        if (sc && !p_clk[id]) begin
            if (ncap[id] < wid[id]) cap[id][ncap[id]] = sd;
            ncap[id]++;
        end
        if (sl && !p_lat[id]) begin
            check("latch_lines_low", {sc, sd}, 0);
            check("bit_count", ncap[id], wid[id]);
            check("frame_expected", erd[id] < ewr[id], 1);
            if (erd[id] < ewr[id]) begin
                e = expf[id][erd[id] % 8];
                erd[id]++;
                got = '0; want = '0;
                for (int i = 0; i < wid[id]; i++) begin
                    got[i]  = cap[id][i];
                    want[i] = msb[id] ? e[wid[id]-1-i] : e[i];
                end
                check("frame_bits", got, want);
            end
            ncap[id] = 0;
        end
        if (sl) lat_len[id]++;
        else if (p_lat[id]) begin
            check("latch_len", lat_len[id], dv[id]);
            lat_len[id] = 0;
        end
        if (bs) busy_len[id]++;
        else if (p_busy[id]) begin
            check("busy_len", busy_len[id], 2*dv[id]*wid[id] + dv[id]);
            busy_len[id] = 0;
        end
        if (dn) begin
            check("done_one_cycle", p_done[id], 0);
            mcnt[id] = (mcnt[id] + 1) % 256;
            check("frame_cnt", fc, mcnt[id]);
            check("idle_lines", {sc, sl, sd, bs}, 0);
        end
        p_clk[id] = sc; p_lat[id] = sl; p_busy[id] = bs; p_done[id] = dn;
    endtask

    always @(negedge clk) begin
        if (aclr) mon_reset();
        else begin
            mon(0, bus_a.shr_clk, bus_a.shr_data, bus_a.shr_latch, bus_a.busy, bus_a.done, bus_a.frame_cnt);
            mon(1, bus_b.shr_clk, bus_b.shr_data, bus_b.shr_latch, bus_b.busy, bus_b.done, bus_b.frame_cnt);
            mon(2, bus_c.shr_clk, bus_c.shr_data, bus_c.shr_latch, bus_c.busy, bus_c.done, bus_c.frame_cnt);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_small(input logic [7:0] p);
        bus_a.pattern = p;
        bus_b.pattern = p;
        push_exp(0, MW'(p));
        push_exp(1, MW'(p));
    endtask

    task automatic drive_udr_small(input logic v);
        bus_a.udr = v;
        bus_b.udr = v;
    endtask

    task automatic pulse_start_small();
        bus_a.start = 1'b1; bus_b.start = 1'b1;
        @(negedge clk);
        bus_a.start = 1'b0; bus_b.start = 1'b0;
    endtask

    task automatic pulse_udr_small();
        drive_udr_small(1'b1);
        repeat (3) @(negedge clk);
        drive_udr_small(1'b0);
        repeat (3) @(negedge clk);
    endtask

    function automatic logic done_of(input int id);
        case (id)
            0:       return bus_a.done;
            1:       return bus_b.done;
            default: return bus_c.done;
        endcase
    endfunction

    task automatic wait_done(input int id);
        int budget;
        int n;
        budget = 2*dv[id]*wid[id] + dv[id] + 40;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done_of(id) && n < budget);
        check("done_within_budget", n < budget, 1);
    endtask

    function automatic logic [MW-1:0] rand_wide();
        logic [MW-1:0] r;
        r = '0;
        for (int i = 0; i < 20; i++) r = {r[MW-33:0], 32'($urandom)};
        return r;
    endfunction

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: got timeout expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [7:0]    p8;
        logic [MW-1:0] pw;

        bus_a.pattern = '0; bus_a.udr = 1'b0; bus_a.start = 1'b0;
        bus_b.pattern = '0; bus_b.udr = 1'b0; bus_b.start = 1'b0;
        bus_c.pattern = '0; bus_c.udr = 1'b0; bus_c.start = 1'b0;

        repeat (3) @(negedge clk);
        check("reset_outputs_a", {bus_a.shr_clk, bus_a.shr_data, bus_a.shr_latch,
                                  bus_a.busy, bus_a.done, bus_a.frame_cnt}, 0);
        check("reset_outputs_c", {bus_c.shr_clk, bus_c.shr_data, bus_c.shr_latch,
                                  bus_c.busy, bus_c.done, bus_c.frame_cnt}, 0);
        aclr = 1'b0;
        repeat (2) @(negedge clk);

        // 1: udr held three cycles, busy three edges later
        set_small(8'hA5);
        drive_udr_small(1'b1);
        repeat (3) @(negedge clk);
        check("busy_before_sync", bus_a.busy, 0);
        drive_udr_small(1'b0);
        @(negedge clk);
        check("busy_rise", bus_a.busy, 1);
        check("first_bit_msb", bus_a.shr_data, 1);
        check("first_bit_lsb", bus_b.shr_data, 1);
        wait_done(0);
        check("frame_cnt_after_first", bus_a.frame_cnt, 1);

        // 2: single set bit, exercises shift direction
        set_small(8'h01);
        pulse_start_small();
        wait_done(0);

        // 3: new pattern + udr mid-transfer becomes the follow-up frame
        set_small(8'hA5);
        pulse_start_small();
        repeat (10) @(negedge clk);
        bus_a.pattern = 8'h3C; bus_b.pattern = 8'h3C;
        push_exp(0, MW'(8'h3C)); push_exp(1, MW'(8'h3C));
        pulse_udr_small();
        wait_done(0);
        @(negedge clk);
        check("pending_restart", bus_a.busy, 1);
        wait_done(0);

        // 4: three triggers while busy collapse to one extra frame
        p8 = 8'($urandom);
        bus_a.pattern = p8; bus_b.pattern = p8;
        push_exp(0, MW'(p8)); push_exp(1, MW'(p8));
        push_exp(0, MW'(p8)); push_exp(1, MW'(p8));
        pulse_start_small();
        repeat (3) pulse_udr_small();
        wait_done(0);
        wait_done(0);
        repeat (60) @(negedge clk);
        check("no_third_frame", bus_a.busy, 0);
        check("expected_drained", ewr[0] - erd[0], 0);

        // 5: reset mid-transfer
        set_small(8'($urandom));
        pulse_start_small();
        repeat (20) @(negedge clk);
        #3 aclr = 1'b1;
        #1 check("abort_outputs", {bus_a.shr_clk, bus_a.shr_data, bus_a.shr_latch,
                                   bus_a.busy, bus_a.done, bus_a.frame_cnt}, 0);
        repeat (2) @(negedge clk);
        aclr = 1'b0;
        repeat (80) @(negedge clk);
        check("no_resume_after_abort", {bus_a.busy, bus_a.shr_latch}, 0);
        set_small(8'($urandom));
        pulse_start_small();
        wait_done(0);
        check("fresh_frame_cnt", bus_a.frame_cnt, 1);

        // 6a: wide chain, divide-by-one
        for (int k = 0; k < 3; k++) begin
            pw = rand_wide();
            bus_c.pattern = pw;
            push_exp(2, pw);
            bus_c.start = 1'b1;
            @(negedge clk);
            bus_c.start = 1'b0;
            wait_done(2);
        end

        // 6b: frame counter wraps after 256 frames
        for (int k = 0; k < 255; k++) begin
            set_small(8'($urandom));
            pulse_start_small();
            wait_done(0);
        end
        check("frame_cnt_wrap", bus_a.frame_cnt, 0);

        repeat (10) @(negedge clk);
        for (int id = 0; id < 3; id++) check("all_frames_seen", ewr[id] - erd[id], 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
